// File: rtl/s2p_lane_arbiter.sv
// Round-robin arbiter sharing one valid/ready byte bus among NCH deserializer lanes.
// Each lane has a 2-entry FIFO and a sticky overflow flag. The output register carries a lane tag.
module s2p_lane_arbiter #(
   parameter int NCH = 4,
   parameter int DW  = 8,
   parameter int CHW = 2
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NCH*DW-1:0]    in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [DW-1:0]        out_data,
   output logic [CHW-1:0]       out_ch,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NCH-1:0]       ovf,
   input  logic [NCH-1:0]       ovf_clr
);

   logic [DW-1:0]     out_data_reg;
   logic [CHW-1:0]    out_ch_reg;
   logic              out_valid_reg;
   logic [CHW-1:0]    ptr_reg;
   logic [NCH-1:0]    ovf_reg;

   logic              free;
   logic [NCH-1:0]    not_empty;
   logic [NCH-1:0]    drop;
   logic [NCH-1:0]    grant_vec;
   logic [NCH*DW-1:0] head_flat;
   logic              found;
   logic [CHW-1:0]    grant_idx;
   logic [CHW-1:0]    cand;

   assign free = !out_valid_reg || out_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_lane
         logic [DW-1:0] mem_reg [2];
         logic          wr_ptr_reg;
         logic          rd_ptr_reg;
         logic [1:0]    count_reg;
         logic          full;
         logic          push;
         logic          pop;

         assign full  = count_reg[1];
         assign pop   = grant_vec[gi];
         // A full lane still accepts a word when its head leaves in the same cycle.
         assign push  = in_valid[gi] && (!full || pop);
         assign drop[gi]      = in_valid[gi] && full && !pop;
         assign not_empty[gi] = (count_reg != 2'd0);
         assign head_flat[gi*DW +: DW] = mem_reg[rd_ptr_reg];

         always_ff @(posedge clk) begin
            if (push)
               mem_reg[wr_ptr_reg] <= in_data[gi*DW +: DW];
         end

         always_ff @(posedge clk) begin
            if (!rstn) begin
               wr_ptr_reg <= 1'b0;
               rd_ptr_reg <= 1'b0;
               count_reg  <= 2'd0;
            end else begin
               if (push)
                  wr_ptr_reg <= ~wr_ptr_reg;
               if (pop)
                  rd_ptr_reg <= ~rd_ptr_reg;
               count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
            end
         end
      end
   endgenerate

   // Candidates are occupancy before this cycle's pushes, so a new word costs one extra cycle.
   always_comb begin
      found     = 1'b0;
      grant_idx = ptr_reg;
      grant_vec = '0;
      cand      = '0;
      if (free) begin
         for (int k = 1; k <= NCH; k++) begin
            cand = CHW'((int'(ptr_reg) + k) % NCH);
            if (!found && not_empty[cand]) begin
               found     = 1'b1;
               grant_idx = cand;
            end
         end
      end
      if (found)
         grant_vec[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_data_reg  <= '0;
         out_ch_reg    <= '0;
         out_valid_reg <= 1'b0;
         ptr_reg       <= CHW'(NCH - 1);
         ovf_reg       <= '0;
      end else begin
         if (free) begin
            if (found) begin
               out_data_reg  <= head_flat[grant_idx*DW +: DW];
               out_ch_reg    <= grant_idx;
               out_valid_reg <= 1'b1;
               ptr_reg       <= grant_idx;
            end else begin
               out_valid_reg <= 1'b0;
            end
         end
         ovf_reg <= (ovf_reg & ~ovf_clr) | drop;
      end
   end

   assign out_data  = out_data_reg;
   assign out_ch    = out_ch_reg;
   assign out_valid = out_valid_reg;
   assign ovf       = ovf_reg;

endmodule

// File: tb/tb_s2p_lane_arbiter.sv
// Directed bench for s2p_lane_arbiter; outputs sampled 1 time unit after each rising edge.
// Output word is compared packed as {out_valid, out_ch, out_data}.
module tb_s2p_lane_arbiter;

   logic        clk;
   logic        rstn;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  ovf;
   logic [3:0]  ovf_clr;

   int n_pass  = 0;
   int n_total = 0;

   s2p_lane_arbiter #(.NCH(4), .DW(8), .CHW(2)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lane(input int i, input logic [7:0] d);
      in_valid[i]       = 1'b1;
      in_data[i*8 +: 8] = d;
   endtask

   task automatic idle();
      in_valid = 4'b0000;
      ovf_clr  = 4'b0000;
   endtask

   function automatic logic [31:0] ow(input logic v, input logic [1:0] c, input logic [7:0] d);
      return {21'b0, v, c, d};
   endfunction

   function automatic logic [31:0] outw();
      return {21'b0, out_valid, out_ch, out_data};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      $display("check %-12s observed %h expected %h", tag, obs, exp);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      idle();
      tick();
      rstn = 1'b1;
   endtask

   initial begin
      rstn      = 1'b0;
      in_valid  = 4'hF;
      in_data   = 32'hFFFF_FFFF;
      out_ready = 1'b1;
      ovf_clr   = 4'h0;

      // reset has priority over in_valid
      tick();
      tick();
      check("rst_out", outw(), ow(0, 0, 8'h00));
      check("rst_ovf", {28'b0, ovf}, 32'h0);
      rstn = 1'b1;
      idle();
      tick();
      tick();
      check("rst_idle", outw(), ow(0, 0, 8'h00));

      // single word, latency 2
      lane(1, 8'h5A);
      tick();
      idle();
      check("t1_c1", outw(), ow(0, 0, 8'h00));
      tick();
      check("t1_c2", outw(), ow(1, 1, 8'h5A));
      tick();
      check("t1_c3", outw(), ow(0, 1, 8'h5A));

      // simultaneous requests
      do_reset();
      lane(0, 8'h10); lane(1, 8'h21); lane(2, 8'h32); lane(3, 8'h43);
      tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("t2_w%0d", i), outw(), ow(1, 2'(i), 8'(8'h10 + i * 8'h11)));
      end
      tick();
      check("t2_end", outw(), ow(0, 3, 8'h43));

      // backpressure
      do_reset();
      out_ready = 1'b0;
      lane(0, 8'h11); lane(1, 8'h22);
      tick();
      idle();
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("t3_hold%0d", i), outw(), ow(1, 0, 8'h11));
      end
      out_ready = 1'b1;
      tick();
      check("t3_next", outw(), ow(1, 1, 8'h22));
      tick();
      check("t3_end", outw(), ow(0, 1, 8'h22));

      // overflow
      do_reset();
      out_ready = 1'b0;
      lane(2, 8'hA1); tick();
      lane(2, 8'hA2); tick();
      lane(2, 8'hA3); tick();
      check("t4_noovf", {28'b0, ovf}, 32'h0);
      lane(2, 8'hA4); tick();
      idle();
      check("t4_ovf", {28'b0, ovf}, 32'h4);
      check("t4_head", outw(), ow(1, 2, 8'hA1));
      out_ready = 1'b1;
      tick();
      check("t4_a2", outw(), ow(1, 2, 8'hA2));
      tick();
      check("t4_a3", outw(), ow(1, 2, 8'hA3));
      tick();
      check("t4_empty", outw(), ow(0, 2, 8'hA3));
      check("t4_sticky", {28'b0, ovf}, 32'h4);
      ovf_clr = 4'b0100;
      tick();
      idle();
      check("t4_clr", {28'b0, ovf}, 32'h0);
      out_ready = 1'b0;
      lane(2, 8'hB1); tick();
      lane(2, 8'hB2); tick();
      lane(2, 8'hB3); tick();
      lane(2, 8'hB4); ovf_clr = 4'b0100; tick();
      idle();
      check("t4_setwins", {28'b0, ovf}, 32'h4);
      check("t4_bhead", outw(), ow(1, 2, 8'hB1));

      // fairness between lanes 0 and 3
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         lane(0, 8'(8'h40 + k));
         lane(3, 8'(8'h70 + k));
         tick();
         if (k > 0)
            check($sformatf("t5_l3_%0d", k - 1), outw(), ow(1, 3, 8'(8'h70 + k - 1)));
         idle();
         tick();
         check($sformatf("t5_l0_%0d", k), outw(), ow(1, 0, 8'(8'h40 + k)));
      end
      tick();
      check("t5_l3_7", outw(), ow(1, 3, 8'h77));
      tick();
      check("t5_end", outw(), ow(0, 3, 8'h77));
      check("t5_ovf", {28'b0, ovf}, 32'h0);

      // reset mid-operation
      do_reset();
      out_ready = 1'b0;
      lane(1, 8'hC1); lane(0, 8'hD1); tick();
      idle();
      lane(1, 8'hC2); tick();
      lane(1, 8'hC3); tick();
      lane(1, 8'hC4); tick();
      idle();
      check("t6_pre_ovf", {28'b0, ovf}, 32'h2);
      check("t6_pre_out", outw(), ow(1, 0, 8'hD1));
      rstn = 1'b0;
      lane(3, 8'hEE);
      tick();
      rstn = 1'b1;
      idle();
      check("t6_rst_out", outw(), ow(0, 0, 8'h00));
      check("t6_rst_ovf", {28'b0, ovf}, 32'h0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("t6_stale%0d", i), outw(), ow(0, 0, 8'h00));
      end
      lane(0, 8'h01); lane(2, 8'h02);
      tick();
      idle();
      tick();
      check("t6_l0first", outw(), ow(1, 0, 8'h01));
      tick();
      check("t6_l2", outw(), ow(1, 2, 8'h02));
      lane(2, 8'h99);
      tick();
      idle();
      check("t6_gap", outw(), ow(0, 2, 8'h02));
      tick();
      check("t6_l2only", outw(), ow(1, 2, 8'h99));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/s2p_lane_arbiter.md
Name: s2p_lane_arbiter

Overview:
Shares one parallel byte output bus among NCH serial-to-parallel lanes. Each lane delivers an 8-bit word with a one-cycle valid pulse. The block buffers each lane's word in a 2-entry FIFO and grants the shared output round-robin. The output uses a valid/ready handshake and carries a lane tag. It sits between the lane deserializers and the downstream byte consumer (packet parser / register bridge).

Parameters:
NCH, 4, number of requesting lanes (2..8)
DW, 8, word width per lane
CHW, 2, width of lane tag; must equal clog2(NCH)

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  synchronous active-low reset
in_data  input  NCH*DW  lane words; lane i on bits [i*DW +: DW]
in_valid  input  NCH  per-lane single-cycle word strobe
out_data  output  DW  granted word
out_ch  output  CHW  lane index of out_data
out_valid  output  1  output word valid
out_ready  input  1  downstream accepts when high with out_valid
ovf  output  NCH  sticky per-lane overflow flags
ovf_clr  input  NCH  per-lane overflow clear strobe

Behaviour:
- Reset is synchronous on rstn low and takes priority over every other event:
  - out_valid=0, out_data=0, out_ch=0, ovf=0.
  - All FIFOs empty, contents discarded.
  - Round-robin pointer = NCH-1, so lane 0 wins first.
  - Reset mid-transfer drops all buffered and presented words. No word is emitted after reset until a new in_valid.
- Lane FIFO: 2 entries per lane, push on in_valid[i].
  - Not full: word stored.
  - Full with a pop from the same lane in the same cycle: push accepted.
  - Full with no pop: word dropped, ovf[i] set, FIFO contents unchanged.
- ovf[i] is set on a drop and cleared by ovf_clr[i]. If set and clear occur in the same cycle, set wins.
- Output register (out_data/out_ch/out_valid) is "free" when out_valid=0 or (out_valid & out_ready).
- Arbitration occurs each cycle the output register is free:
  - Candidates are lanes with non-empty FIFOs, sampled before this cycle's pushes.
  - Search starts at pointer+1 modulo NCH; the first non-empty lane wins.
  - The winner's FIFO head is popped into the output register, out_ch = winner, out_valid=1, pointer = winner.
- If free and no candidate: out_valid goes 0; out_data/out_ch hold their last values.
- If not free: out_data/out_ch/out_valid hold stable, nothing is popped, and the pointer is unchanged.
- Latency: in_valid in cycle t gives out_valid in cycle t+2 at the earliest (FIFO write at edge t, output load at edge t+1).
- Throughput: one word per cycle with out_ready held high.
- Fairness: a continuously non-empty lane waits at most NCH-1 grants.
- Order within a lane is preserved. There is no ordering guarantee across lanes.
- Maximum buffering per lane: 2 FIFO entries plus the output register when that lane holds it.

Test Plan:
- Single word: reset, in_valid[1] with 0x5A in cycle 0, out_ready=1 -> out_valid=1, out_data=0x5A, out_ch=1 in cycle 2 only; out_valid=0 in cycle 3.
- Simultaneous requests: all lanes pulse in one cycle with 0x10, 0x21, 0x32, 0x43, out_ready=1 -> outputs on consecutive cycles, lane order 0, 1, 2, 3, data matching.
- Backpressure: out_ready=0 while out_valid=1 for 5 cycles -> out_data/out_ch stable. On out_ready=1, the next queued word appears the following cycle with no loss or duplication.
- Overflow: out_ready=0, lane 2 sends 0xA1, 0xA2, 0xA3, 0xA4 on cycles 0-3:
  - 0xA4 dropped, ovf[2]=1 from cycle 4.
  - Release out_ready -> exactly 0xA1, 0xA2, 0xA3 emitted.
  - ovf_clr[2] pulse clears ovf[2]. A drop in the same cycle as ovf_clr keeps ovf[2]=1.
- Fairness: lanes 0 and 3 each push every other cycle, out_ready=1 -> grants alternate 0, 3, 0, 3; neither lane overflows.
- Reset mid-operation: FIFOs partially full and out_valid=1, rstn low one cycle -> out_valid=0 and ovf=0 next cycle, no stale words afterwards. The first new word from lane 2 is granted ahead of lane 0 only if lane 0 is empty.
